// File: rtl/dcache_pkg.sv
// Shared constants and types for the data-cache load-return path.
// Load op codes, line geometry and the refill FSM states.
package dcache_pkg;

  localparam int LINE_W = 128;
  localparam int WORD_W = 32;
  localparam int BEATS  = 4;

  typedef enum logic [2:0] {
    LD_B  = 3'd0,
    LD_H  = 3'd1,
    LD_W  = 3'd2,
    LD_BU = 3'd3,
    LD_HU = 3'd4
  } ld_op_e;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_REFILL = 1'b1
  } state_e;

endpackage

// File: rtl/load_extend.sv
// Byte/halfword/word extraction with sign or zero extension.
// Unknown op codes pass the full word through.
module load_extend
  import dcache_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [1:0]        off,
  input  logic [2:0]        op,
  output logic [WORD_W-1:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b      = word[{off, 3'b000} +: 8];
    h      = off[1] ? word[31:16] : word[15:0];
    result = word;
    case (ld_op_e'(op))
      LD_B:    result = {{24{b[7]}}, b};
      LD_BU:   result = {24'd0, b};
      LD_H:    result = {{16{h[15]}}, h};
      LD_HU:   result = {16'd0, h};
      LD_W:    result = word;
      default: result = word;
    endcase
  end

endmodule

// File: rtl/dcache_load_return.sv
// Load-return stage: extends hit data, or gathers a refill line
// from the bus and returns the requested word from it.
module dcache_load_return
  import dcache_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  input  logic [1:0]        hit,
  input  logic [LINE_W-1:0] line_data,
  input  logic [3:0]        offset,
  input  logic [2:0]        ld_op,
  input  logic              ret_valid,
  input  logic              ret_last,
  input  logic [WORD_W-1:0] ret_data,
  output logic              busy,
  output logic              rdata_valid,
  output logic [WORD_W-1:0] rdata,
  output logic              refill_valid,
  output logic [LINE_W-1:0] refill_line,
  output logic              multi_hit
);

  state_e            state;
  logic [1:0]        cnt;
  logic [WORD_W-1:0] buffer [BEATS];
  logic [WORD_W-1:0] buf_nx [BEATS];
  logic [3:0]        lat_off;
  logic [2:0]        lat_op;

  logic              in_refill;
  logic              beat;
  logic [LINE_W-1:0] line_nx;
  logic [WORD_W-1:0] hit_word;
  logic [WORD_W-1:0] ext_word;
  logic [1:0]        ext_off;
  logic [2:0]        ext_op;
  logic [WORD_W-1:0] ext_res;

  assign in_refill = (state == S_REFILL);
  assign busy      = in_refill;
  assign beat      = in_refill && ret_valid;

  // Buffer as it will look after this cycle's beat, so the
  // completing beat is visible to both line and word returns.
  always_comb begin
    for (int i = 0; i < BEATS; i++) begin
      buf_nx[i] = (beat && cnt == 2'(i)) ? ret_data : buffer[i];
    end
  end

  assign line_nx  = {buf_nx[3], buf_nx[2], buf_nx[1], buf_nx[0]};
  assign hit_word = line_data[{offset[3:2], 5'b00000} +: WORD_W];
  assign ext_word = in_refill ? buf_nx[lat_off[3:2]] : hit_word;
  assign ext_off  = in_refill ? lat_off[1:0] : offset[1:0];
  assign ext_op   = in_refill ? lat_op : ld_op;

  load_extend u_ext (
    .word   (ext_word),
    .off    (ext_off),
    .op     (ext_op),
    .result (ext_res)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      cnt          <= '0;
      buffer       <= '{default: '0};
      lat_off      <= '0;
      lat_op       <= '0;
      rdata_valid  <= 1'b0;
      rdata        <= '0;
      refill_valid <= 1'b0;
      refill_line  <= '0;
      multi_hit    <= 1'b0;
    end else begin
      rdata_valid  <= 1'b0;
      refill_valid <= 1'b0;
      multi_hit    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (hit == 2'b00) begin
              lat_off <= offset;
              lat_op  <= ld_op;
              cnt     <= '0;
              buffer  <= '{default: '0};
              state   <= S_REFILL;
            end else begin
              rdata       <= ext_res;
              rdata_valid <= 1'b1;
              multi_hit   <= &hit;
            end
          end
        end
        S_REFILL: begin
          if (ret_valid) begin
            buffer[cnt] <= ret_data;
            cnt         <= cnt + 2'd1;
            if (ret_last) begin
              refill_line  <= line_nx;
              refill_valid <= 1'b1;
              rdata        <= ext_res;
              rdata_valid  <= 1'b1;
              state        <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_load_return.sv
// Randomized self-checking bench for dcache_load_return.
// Expected values come from an arithmetic load/refill model.
module tb_dcache_load_return;

  logic         clk = 1'b0;
  logic         rstn;
  logic         req_valid;
  logic [1:0]   hit;
  logic [127:0] line_data;
  logic [3:0]   offset;
  logic [2:0]   ld_op;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
  logic         busy;
  logic         rdata_valid;
  logic [31:0]  rdata;
  logic         refill_valid;
  logic [127:0] refill_line;
  logic         multi_hit;

  int checks = 0;
  int errors = 0;

  logic [31:0] beat_data [8];

  dcache_load_return dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .hit          (hit),
    .line_data    (line_data),
    .offset       (offset),
    .ld_op        (ld_op),
    .ret_valid    (ret_valid),
    .ret_last     (ret_last),
    .ret_data     (ret_data),
    .busy         (busy),
    .rdata_valid  (rdata_valid),
    .rdata        (rdata),
    .refill_valid (refill_valid),
    .refill_line  (refill_line),
    .multi_hit    (multi_hit)
  );

  always #5 clk = ~clk;

  // Reference: shift the addressed field down, then extend.
  function automatic logic [31:0] ref_ext(input logic [31:0] w,
                                          input int off,
                                          input int op);
    int unsigned v;
    int unsigned bsh;
    int unsigned hsh;
    bsh = 8 * (off % 4);
    hsh = 16 * ((off % 4) / 2);
    case (op)
      0: begin
        v = (w >> bsh) & 32'hFF;
        if (v >= 128) v = v + 32'hFFFF_FF00;
      end
      3: v = (w >> bsh) & 32'hFF;
      1: begin
        v = (w >> hsh) & 32'hFFFF;
        if (v >= 32768) v = v + 32'hFFFF_0000;
      end
      4: v = (w >> hsh) & 32'hFFFF;
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] l,
                                          input int idx);
    return 32'(l >> (32 * idx));
  endfunction

  // Line after n beats: slots start at 0, beat k lands in slot k mod 4.
  function automatic logic [127:0] exp_line(input int n);
    logic [31:0] w [4];
    w = '{default: 32'h0};
    for (int k = 0; k < n; k++) w[k % 4] = beat_data[k];
    return {w[3], w[2], w[1], w[0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    req_valid = 1'b0;
    hit       = 2'b00;
    line_data = '0;
    offset    = '0;
    ld_op     = '0;
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    ret_data  = '0;
  endtask

  task automatic drive_req(input logic [1:0] h, input logic [127:0] l,
                           input logic [3:0] off, input logic [2:0] op);
    req_valid = 1'b1;
    hit       = h;
    line_data = l;
    offset    = off;
    ld_op     = op;
  endtask

  // Miss request with a decoy last-beat in the same cycle.
  task automatic start_miss(input logic [3:0] off, input logic [2:0] op);
    drive_req(2'b00, {4{32'hA5A5_5A5A}}, off, op);
    ret_valid = 1'b1;
    ret_last  = 1'b1;
    ret_data  = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
  endtask

  // Streams n beats; reports cycles where busy dropped or a pulse came early.
  task automatic send_beats(input int n, input bit gaps, input bit stray,
                            output int bad_busy, output int early);
    bad_busy = 0;
    early    = 0;
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        for (int j = 0; j < g; j++) begin
          ret_valid = 1'b0;
          if (stray) drive_req(2'b01, {4{$urandom}}, 4'h0, 3'd2);
          if (busy !== 1'b1) bad_busy++;
          tick();
          req_valid = 1'b0;
          if (rdata_valid || refill_valid || multi_hit) early++;
        end
      end
      ret_valid = 1'b1;
      ret_data  = beat_data[k];
      ret_last  = (k == n - 1);
      if (stray) drive_req(2'b11, {4{$urandom}}, 4'h0, 3'd2);
      if (busy !== 1'b1) bad_busy++;
      tick();
      req_valid = 1'b0;
      if (k < n - 1 && (rdata_valid || refill_valid || multi_hit)) early++;
    end
    ret_valid = 1'b0;
    ret_last  = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rstn = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy, rdata_valid, refill_valid, multi_hit} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b want=0000",
               {busy, rdata_valid, refill_valid, multi_hit});
    end
    checks++;
    if (rdata !== 32'h0 || refill_line !== 128'h0) begin
      errors++;
      $display("FAIL reset_data rdata=%h line=%h want 0", rdata, refill_line);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_hit_directed;
    logic [127:0] l;
    l = {32'h0, 32'h0, 32'h80FF_7F01, 32'h0};
    drive_req(2'b01, l, 4'h7, 3'd0);
    tick();
    req_valid = 1'b0;
    checks++;
    if (rdata_valid !== 1'b1 || rdata !== 32'hFFFF_FF80 || multi_hit !== 1'b0) begin
      errors++;
      $display("FAIL hit_lb v=%b d=%h mh=%b want 1 ffffff80 0",
               rdata_valid, rdata, multi_hit);
    end
    tick();
    checks++;
    if (rdata_valid !== 1'b0 || rdata !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL hit_pulse_hold v=%b d=%h want 0 ffffff80",
               rdata_valid, rdata);
    end
    l = {32'hBEEF_1234, 96'h0};
    drive_req(2'b10, l, 4'hE, 3'd4);
    tick();
    req_valid = 1'b0;
    checks++;
    if (rdata_valid !== 1'b1 || rdata !== 32'h0000_BEEF) begin
      errors++;
      $display("FAIL hit_lhu v=%b d=%h want 1 0000beef", rdata_valid, rdata);
    end
    tick();
  endtask

  task automatic test_multi_hit;
    drive_req(2'b11, {96'h0, 32'hCAFE_0000}, 4'h0, 3'd2);
    tick();
    req_valid = 1'b0;
    checks++;
    if (rdata_valid !== 1'b1 || rdata !== 32'hCAFE_0000 || multi_hit !== 1'b1) begin
      errors++;
      $display("FAIL multi_hit v=%b d=%h mh=%b want 1 cafe0000 1",
               rdata_valid, rdata, multi_hit);
    end
    tick();
    checks++;
    if (multi_hit !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL multi_hit_pulse mh=%b busy=%b want 0 0", multi_hit, busy);
    end
  endtask

  task automatic test_miss_full;
    int bb, ea;
    beat_data[0] = 32'h11;
    beat_data[1] = 32'h22;
    beat_data[2] = 32'h33;
    beat_data[3] = 32'h44;
    start_miss(4'h8, 3'd2);
    checks++;
    if (busy !== 1'b1 || rdata_valid !== 1'b0) begin
      errors++;
      $display("FAIL miss_busy busy=%b v=%b want 1 0", busy, rdata_valid);
    end
    send_beats(4, 1'b0, 1'b0, bb, ea);
    checks++;
    if (bb != 0 || ea != 0) begin
      errors++;
      $display("FAIL miss_during bad_busy=%0d early=%0d want 0 0", bb, ea);
    end
    checks++;
    if (refill_valid !== 1'b1 || rdata_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL miss_done rv=%b dv=%b busy=%b want 1 1 0",
               refill_valid, rdata_valid, busy);
    end
    checks++;
    if (refill_line !== 128'h00000044_00000033_00000022_00000011 ||
        rdata !== 32'h33) begin
      errors++;
      $display("FAIL miss_data line=%h d=%h want 00000044000000330000002200000011 00000033",
               refill_line, rdata);
    end
    tick();
    checks++;
    if (refill_valid !== 1'b0 || rdata_valid !== 1'b0) begin
      errors++;
      $display("FAIL miss_pulse rv=%b dv=%b want 0 0", refill_valid, rdata_valid);
    end
  endtask

  task automatic test_short_burst;
    int bb, ea;
    beat_data[0] = 32'h8765_4321;
    beat_data[1] = 32'hFFFF_8001;
    start_miss(4'h6, 3'd1);
    send_beats(2, 1'b1, 1'b0, bb, ea);
    checks++;
    if (bb != 0 || ea != 0 || refill_valid !== 1'b1 ||
        refill_line !== {64'h0, 32'hFFFF_8001, 32'h8765_4321}) begin
      errors++;
      $display("FAIL short_line bb=%0d ea=%0d rv=%b line=%h want 0 0 1 %h",
               bb, ea, refill_valid, refill_line,
               {64'h0, 32'hFFFF_8001, 32'h8765_4321});
    end
    checks++;
    if (rdata !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL short_word got=%h want ffffffff", rdata);
    end
    drive_req(2'b01, {96'h0, 32'h0000_007F}, 4'h0, 3'd0);
    tick();
    req_valid = 1'b0;
    checks++;
    if (rdata_valid !== 1'b1 || rdata !== 32'h7F) begin
      errors++;
      $display("FAIL back_to_back v=%b d=%h want 1 0000007f", rdata_valid, rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_refill;
    start_miss(4'h4, 3'd2);
    for (int k = 0; k < 2; k++) begin
      ret_valid = 1'b1;
      ret_data  = 32'h5000 + k;
      tick();
    end
    ret_valid = 1'b0;
    rstn = 1'b0;
    #1;
    checks++;
    if ({busy, rdata_valid, refill_valid, multi_hit} !== 4'b0 ||
        rdata !== 32'h0 || refill_line !== 128'h0) begin
      errors++;
      $display("FAIL reset_mid flags=%b d=%h line=%h want 0",
               {busy, rdata_valid, refill_valid, multi_hit}, rdata, refill_line);
    end
    tick();
    rstn = 1'b1;
    tick();
    checks++;
    if (rdata_valid !== 1'b0 || refill_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_pulse dv=%b rv=%b busy=%b want 0 0 0",
               rdata_valid, refill_valid, busy);
    end
    drive_req(2'b10, {32'h0, 32'h0, 32'h1234_8000, 32'h0}, 4'h6, 3'd1);
    tick();
    req_valid = 1'b0;
    checks++;
    if (rdata_valid !== 1'b1 || rdata !== 32'h0000_1234) begin
      errors++;
      $display("FAIL reset_mid_hit v=%b d=%h want 1 00001234", rdata_valid, rdata);
    end
    tick();
  endtask

  task automatic test_random;
    logic [127:0] l;
    logic [1:0]   h;
    logic [3:0]   off;
    logic [2:0]   op;
    logic [31:0]  ew;
    logic [127:0] el;
    int n, bb, ea;
    for (int t = 0; t < 150; t++) begin
      l   = {$urandom, $urandom, $urandom, $urandom};
      h   = 2'($urandom_range(0, 3));
      off = 4'($urandom);
      op  = 3'($urandom_range(0, 7));
      if (h != 2'b00) begin
        ew = ref_ext(word_of(l, off / 4), off, op);
        drive_req(h, l, off, op);
        if ($urandom_range(0, 1) == 1) begin
          ret_valid = 1'b1;
          ret_last  = 1'b1;
          ret_data  = $urandom;
        end
        tick();
        idle_inputs();
        checks++;
        if (rdata_valid !== 1'b1 || rdata !== ew || busy !== 1'b0 ||
            multi_hit !== (h == 2'b11) || refill_valid !== 1'b0) begin
          errors++;
          $display("FAIL rand_hit t=%0d h=%b off=%h op=%0d v=%b d=%h mh=%b want %h",
                   t, h, off, op, rdata_valid, rdata, multi_hit, ew);
        end
      end else begin
        n = $urandom_range(1, 7);
        for (int k = 0; k < 8; k++) beat_data[k] = $urandom;
        el = exp_line(n);
        ew = ref_ext(word_of(el, off / 4), off, op);
        start_miss(off, op);
        send_beats(n, 1'b1, 1'b1, bb, ea);
        checks++;
        if (bb != 0 || ea != 0 || refill_valid !== 1'b1 || rdata_valid !== 1'b1 ||
            busy !== 1'b0 || multi_hit !== 1'b0 ||
            refill_line !== el || rdata !== ew) begin
          errors++;
          $display("FAIL rand_miss t=%0d n=%0d off=%h op=%0d bb=%0d ea=%0d rv=%b dv=%b line=%h d=%h want line=%h d=%h",
                   t, n, off, op, bb, ea, refill_valid, rdata_valid,
                   refill_line, rdata, el, ew);
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        tick();
        checks++;
        if (rdata_valid !== 1'b0 || refill_valid !== 1'b0 || multi_hit !== 1'b0) begin
          errors++;
          $display("FAIL rand_idle t=%0d dv=%b rv=%b mh=%b want 0 0 0",
                   t, rdata_valid, refill_valid, multi_hit);
        end
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_hit_directed();
    test_multi_hit();
    test_miss_full();
    test_short_burst();
    test_reset_mid_refill();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_load_return.md
# dcache_load_return

Load-return stage of the data cache, directly downstream of the 2-way hit multiplexer. It consumes the selected 128-bit line and the hit vector, and returns the aligned, sign/zero-extended 32-bit load word to the pipeline one cycle after lookup. On a miss it collects the four 32-bit refill beats from the bus into a line buffer. It then hands the completed line to the cache write port and returns the requested word from that buffer.

## Interface
- No parameters. Line width 128, word width 32 and beat count 4 are fixed package constants.
- `clk`  in  1  — single clock domain.
- `rstn`  in  1  — asynchronous, active-low reset.
- `req_valid`  in  1  — lookup result valid this cycle.
- `hit`  in  2  — way hit vector. `00` means miss; `01` or `10` means hit; `11` is a multi-hit.
- `line_data`  in  128  — line selected by the hit mux.
- `offset`  in  4  — byte offset within the line. `[3:2]` selects the word and `[1:0]` selects the byte.
- `ld_op`  in  3  — load type from the package: `LD_B`=0, `LD_H`=1, `LD_W`=2, `LD_BU`=3, `LD_HU`=4.
- `ret_valid`  in  1  — refill beat valid.
- `ret_last`  in  1  — final refill beat.
- `ret_data`  in  32  — refill beat data. Beats arrive in order word0..word3.
- `busy`  out  1  — refill in progress; upstream must hold `req_valid` low.
- `rdata_valid`  out  1  — one-cycle pulse.
- `rdata`  out  32  — extended load result.
- `refill_valid`  out  1  — one-cycle pulse; `refill_line` is to be written into the victim way.
- `refill_line`  out  128  — assembled line. Word0 is bits `[31:0]`.
- `multi_hit`  out  1  — one-cycle pulse when a request arrives with `hit==11`.

## Operation
- States are IDLE and REFILL. Reset state is IDLE.
- A request is accepted when `req_valid && !busy`.
- **Hit (`01`/`10`):** select word `offset[3:2]` of `line_data`, then extract and extend per `ld_op`. Register the result into `rdata` and pulse `rdata_valid`. The state stays IDLE.
- **Multi-hit (`11`):** handle as a hit using `line_data` as supplied, and additionally pulse `multi_hit`.
- **Miss (`00`):**
  - Latch `offset` and `ld_op`.
  - Clear the line buffer and the 2-bit beat counter.
  - Go to REFILL.
- **In REFILL, each `ret_valid`:** write `ret_data` into `buffer[cnt]`, then increment `cnt` (it wraps from 3 to 0).
- **REFILL completes on `ret_valid && ret_last`, whatever the value of `cnt`:**
  - Write the last beat into `buffer[cnt]`.
  - Present the full buffer, including the last beat, on `refill_line` with `refill_valid`.
  - Present the latched word, extracted and extended, on `rdata` with `rdata_valid`.
  - Return to IDLE.
- Words never received in a short burst read as 0. Extra beats beyond 4 without `ret_last` overwrite from word0.
- `ret_valid` in IDLE is ignored.
- **Extraction:**
  - `LD_B`/`LD_BU` use byte `offset[1:0]`.
  - `LD_H`/`LD_HU` use halfword `offset[1]` and ignore `offset[0]`.
  - `LD_W` ignores `offset[1:0]`.
  - B/H sign-extend; BU/HU zero-extend.
  - Undefined `ld_op` codes (5–7) return the full word.
- `req_valid` asserted while `busy` is ignored and not queued.

## Timing
- Reset values:
  - `busy`, `rdata_valid`, `refill_valid` and `multi_hit` are 0.
  - `rdata` and `refill_line` are 0.
  - The buffer and `cnt` are 0.
- Hit latency: request accepted at cycle T gives `rdata_valid` (and `multi_hit` if applicable) at T+1, all registered.
- Miss:
  - Request at T.
  - `busy`=1 from T+1 up to and including the `ret_last` cycle L.
  - `rdata_valid` and `refill_valid` pulse together at L+1.
  - `busy`=0 at L+1, so a new request can be accepted at L+1.
- A beat arriving in the same cycle as the miss request (cycle T) is ignored; beats are sampled only in REFILL.
- `rstn` low mid-refill returns the block to IDLE immediately:
  - The buffer is cleared.
  - No `refill_valid` or `rdata_valid` is produced for the aborted request.
- All pulses last exactly one cycle. The `rdata` and `refill_line` values hold until the next update.

## Structure
- Package `dcache_pkg` holds:
  - the `ld_op` codes as a `typedef enum logic [2:0]`;
  - `LINE_W`=128, `WORD_W`=32, `BEATS`=4;
  - the state enum.
- One sub-module, `load_extend`, is combinational: it takes word, `offset[1:0]` and `ld_op`, and returns the 32-bit result. It is shared by the hit and refill-return paths.

## Test plan
- **Hit, signed byte:** `hit=01`, `line_data` word1=`0x80FF_7F01`, `offset=4'h7`, `LD_B` → `rdata=0xFFFF_FF80`, `rdata_valid` at T+1.
- **Hit way2, unsigned halfword:** `hit=10`, word3=`0xBEEF_1234`, `offset=4'hE`, `LD_HU` → `rdata=0x0000_BEEF`.
- **Miss with 4 beats:**
  - Stimulus: `offset=4'h8`, `LD_W`; beats `0x11`, `0x22`, `0x33`, `0x44` with last on the 4th.
  - Required: `busy` covers the refill; `refill_line=0x00000044_00000033_00000022_00000011`; `rdata=0x33`, with both pulses at L+1.
- **Short burst:** `ret_last` on the 2nd beat → `refill_line` upper two words are 0. A request at L+1 is accepted.
- **Multi-hit:** `hit=11`, `LD_W`, `offset=0`, word0=`0xCAFE_0000` → `rdata=0xCAFE_0000` and `multi_hit` pulse.
- **Reset mid-refill:** `rstn` low after 2 beats → all outputs 0 with no pulses. After release, a hit request behaves normally.
